// File: rtl/tank_round_ctrl.sv
// Round sequencer for the tank game: spawn load, countdown, play gating,
// winner decision with a settle window, and score keeping for the hex display.
module tank_round_ctrl #(
  parameter int unsigned COUNTDOWN_FRAMES = 120,
  parameter int unsigned SETTLE_FRAMES    = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        maze_ready,
  input  logic [19:0] spawn_pos,
  input  logic [1:0]  game_reset,
  input  logic [1:0]  tank_hit,
  output logic        tank_load,
  output logic [9:0]  tank0_spawn,
  output logic [9:0]  tank1_spawn,
  output logic        play_en,
  output logic [1:0]  game_end,
  output logic [15:0] hex_digits
);

  // state     | meaning
  // IDLE      | waiting for a maze_ready rising edge
  // LOAD      | tank_load pulse, spawn cells valid
  // COUNTDOWN | counting frames before play
  // PLAY      | tanks active, no hit yet
  // SETTLE    | first hit seen, collecting near-simultaneous hits
  // RESULT    | game_end held until software acknowledges
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] COUNTDOWN = 3'd2;
  localparam logic [2:0] PLAY      = 3'd3;
  localparam logic [2:0] SETTLE    = 3'd4;
  localparam logic [2:0] RESULT    = 3'd5;

  localparam logic [7:0] CD_INIT = 8'(COUNTDOWN_FRAMES);
  localparam logic [7:0] ST_INIT = 8'(SETTLE_FRAMES);

  logic [2:0] state_q, state_d;
  logic       maze_ready_q;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] hit_mask_q, hit_mask_d, hit_mask_new;
  logic       tank_load_q, tank_load_d;
  logic [9:0] tank0_spawn_q, tank0_spawn_d;
  logic [9:0] tank1_spawn_q, tank1_spawn_d;
  logic       play_en_q, play_en_d;
  logic [1:0] game_end_q, game_end_d;
  logic [3:0] score0_q, score0_d;
  logic [3:0] score1_q, score1_d;
  logic [7:0] round_cnt_q, round_cnt_d;

  assign hit_mask_new = hit_mask_q | tank_hit;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hit_mask_d    = hit_mask_q;
    tank_load_d   = 1'b0;
    tank0_spawn_d = tank0_spawn_q;
    tank1_spawn_d = tank1_spawn_q;
    play_en_d     = play_en_q;
    game_end_d    = game_end_q;
    score0_d      = score0_q;
    score1_d      = score1_q;
    round_cnt_d   = round_cnt_q;

    case (state_q)
      IDLE: begin
        play_en_d = 1'b0;
        if (maze_ready && !maze_ready_q) begin
          state_d       = LOAD;
          tank_load_d   = 1'b1;
          tank0_spawn_d = spawn_pos[9:0];
          tank1_spawn_d = spawn_pos[19:10];
          cnt_d         = CD_INIT;
          hit_mask_d    = 2'b00;
        end
      end
      LOAD: state_d = COUNTDOWN;
      COUNTDOWN: begin
        if (frame_tick) begin
          if (cnt_q == 8'd1) begin
            state_d   = PLAY;
            play_en_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      PLAY: begin
        if (tank_hit != 2'b00) begin
          hit_mask_d = hit_mask_new;
          cnt_d      = ST_INIT;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        hit_mask_d = hit_mask_new;
        if (frame_tick) begin
          if (cnt_q == 8'd1) begin
            // A hit on tank0 means tank1 won, hence the bit swap.
            state_d     = RESULT;
            game_end_d  = {hit_mask_new[0], hit_mask_new[1]};
            play_en_d   = 1'b0;
            round_cnt_d = round_cnt_q + 8'd1;
            if (hit_mask_new == 2'b10 && score0_q < 4'd9) score0_d = score0_q + 4'd1;
            if (hit_mask_new == 2'b01 && score1_q < 4'd9) score1_d = score1_q + 4'd1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      RESULT: begin
        if (game_reset[0]) begin
          state_d    = IDLE;
          game_end_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase

    if (game_reset[1]) begin
      state_d     = IDLE;
      score0_d    = 4'd0;
      score1_d    = 4'd0;
      round_cnt_d = 8'd0;
      game_end_d  = 2'b00;
      play_en_d   = 1'b0;
      tank_load_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      maze_ready_q  <= 1'b0;
      cnt_q         <= 8'd0;
      hit_mask_q    <= 2'b00;
      tank_load_q   <= 1'b0;
      tank0_spawn_q <= 10'd0;
      tank1_spawn_q <= 10'd0;
      play_en_q     <= 1'b0;
      game_end_q    <= 2'b00;
      score0_q      <= 4'd0;
      score1_q      <= 4'd0;
      round_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      maze_ready_q  <= maze_ready;
      cnt_q         <= cnt_d;
      hit_mask_q    <= hit_mask_d;
      tank_load_q   <= tank_load_d;
      tank0_spawn_q <= tank0_spawn_d;
      tank1_spawn_q <= tank1_spawn_d;
      play_en_q     <= play_en_d;
      game_end_q    <= game_end_d;
      score0_q      <= score0_d;
      score1_q      <= score1_d;
      round_cnt_q   <= round_cnt_d;
    end
  end

  assign tank_load   = tank_load_q;
  assign tank0_spawn = tank0_spawn_q;
  assign tank1_spawn = tank1_spawn_q;
  assign play_en     = play_en_q;
  assign game_end    = game_end_q;
  assign hex_digits  = {score0_q, score1_q, round_cnt_q};

endmodule
